// File: rtl/natv_apb4_pkg.sv
// rtl/natv_apb4_pkg.sv - shared types and constants for the native-to-APB4 bridge
package natv_apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } natv_apb4_state_e;

  localparam int TMO_CNT_W = 8;

  localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_if.sv
// rtl/apb4_if.sv - APB4 bus bundle with master and slave views
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/natv_apb4_tmo.sv
// rtl/natv_apb4_tmo.sv - ACCESS-phase wait counter; flags the cycle a hung transfer must abort
module natv_apb4_tmo #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // hit fires in the ACCESS cycle that would be the TIMEOUT_CYCLES-th without pready
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit = (TIMEOUT_CYCLES > 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/natv_apb4_bridge.sv
// rtl/natv_apb4_bridge.sv - converts one native valid/ready request into one APB4 transfer
module natv_apb4_bridge
  import natv_apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    nat_valid_i,
  input  logic [ADDR_WIDTH-1:0]   nat_addr_i,
  input  logic [DATA_WIDTH-1:0]   nat_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] nat_wstrb_i,
  output logic                    nat_ready_o,
  output logic [DATA_WIDTH-1:0]   nat_rdata_o,
  output logic                    nat_err_o,
  output logic [TMO_CNT_W-1:0]    tmo_cnt_o,
  apb4_if.master                  apb
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  natv_apb4_state_e state_q, state_d;

  logic                  wait_clr;
  logic                  wait_en;
  logic                  tmo_hit;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [2:0]            prot_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_WIDTH-1:0] pstrb_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [TMO_CNT_W-1:0]  tmo_cnt_q;

  natv_apb4_tmo #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .clr  (wait_clr),
    .en   (wait_en),
    .hit  (tmo_hit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_clr = 1'b0;
    wait_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (nat_valid_i) begin
          state_d  = SETUP;
          wait_clr = 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        wait_en = !apb.pready;
        if (apb.pready || tmo_hit) begin
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      paddr_q   <= '0;
      prot_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (nat_valid_i) begin
            // a zero strobe is a read, so pstrb is already zero for reads
            paddr_q  <= nat_addr_i & WORD_MASK;
            prot_q   <= APB_PROT_DEFAULT;
            pwrite_q <= |nat_wstrb_i;
            pwdata_q <= nat_wdata_i;
            pstrb_q  <= nat_wstrb_i;
            psel_q   <= 1'b1;
          end
        end
        SETUP: penable_q <= 1'b1;
        ACCESS: begin
          if (apb.pready || tmo_hit) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ready_q   <= 1'b1;
            if (apb.pready) begin
              // error responses and writes carry no data back to the core
              err_q   <= apb.pslverr;
              rdata_q <= (pwrite_q || apb.pslverr) ? '0 : apb.prdata;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
              end
            end
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign apb.paddr   = paddr_q;
  assign apb.pprot   = prot_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

  assign nat_ready_o = ready_q;
  assign nat_rdata_o = rdata_q;
  assign nat_err_o   = err_q;
  assign tmo_cnt_o   = tmo_cnt_q;

endmodule

// File: tb/tb_natv_apb4_bridge.sv
// tb/tb_natv_apb4_bridge.sv - self-checking bench for natv_apb4_bridge
module tb_natv_apb4_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nat_valid;
  logic [31:0] nat_addr;
  logic [31:0] nat_wdata;
  logic [3:0]  nat_wstrb;
  logic        nat_ready;
  logic [31:0] nat_rdata;
  logic        nat_err;
  logic [7:0]  tmo_cnt;

  logic        valid0;
  logic        ready0;
  logic [31:0] rdata0;
  logic        err0;
  logic [7:0]  tmo_cnt0;

  apb4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  apb4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  always #5 clk = ~clk;

  natv_apb4_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .nat_valid_i(nat_valid), .nat_addr_i(nat_addr),
    .nat_wdata_i(nat_wdata), .nat_wstrb_i(nat_wstrb), .nat_ready_o(nat_ready),
    .nat_rdata_o(nat_rdata), .nat_err_o(nat_err), .tmo_cnt_o(tmo_cnt), .apb(bus)
  );

  natv_apb4_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)
  ) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .nat_valid_i(valid0), .nat_addr_i(nat_addr),
    .nat_wdata_i(nat_wdata), .nat_wstrb_i(nat_wstrb), .nat_ready_o(ready0),
    .nat_rdata_o(rdata0), .nat_err_o(err0), .tmo_cnt_o(tmo_cnt0), .apb(bus0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // programmable slave: sl_wait wait states then pready; negative means never ready
  int          sl_wait = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err = 1'b0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && bus.psel && bus.penable) begin
      bus.pready  = (sl_wait >= 0) && (acc_cnt == sl_wait);
      bus.prdata  = sl_rdata;
      bus.pslverr = bus.pready && sl_err;
      acc_cnt++;
    end else begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      acc_cnt     = 0;
    end
  end

  // transaction-schedule model: one transfer = SETUP, access_len ACCESS cycles, RESP
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_a = 0;
  int          m_r = 0;
  int          last_r = -100;
  int          m_len = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic        m_wr, m_err;
  int          m_tmo = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      last_r = -100;
      m_tmo  = 0;
      cyc++;
    end else begin
      cyc++;
      if (m_act && cyc == m_r && m_to && m_tmo < 255) m_tmo++;
      if (nat_valid && cyc >= last_r + 2) begin
        if (sl_wait >= 0 && sl_wait < TMO) begin
          m_len = sl_wait + 1;
          m_to  = 1'b0;
        end else begin
          m_len = TMO;
          m_to  = 1'b1;
        end
        m_act   = 1'b1;
        m_a     = cyc;
        m_r     = cyc + 1 + m_len;
        last_r  = m_r;
        m_addr  = nat_addr & 32'hFFFF_FFFC;
        m_wr    = |nat_wstrb;
        m_strb  = m_wr ? nat_wstrb : 4'h0;
        m_wdata = nat_wdata;
        m_err   = m_to || sl_err;
        m_rdata = (m_to || m_wr || sl_err) ? 32'h0 : sl_rdata;
      end
    end
  end

  bit ep, ee, er;

  always @(negedge clk) begin
    ep = rst_n && m_act && cyc >= m_a && cyc < m_r;
    ee = rst_n && m_act && cyc >= m_a + 1 && cyc < m_r;
    er = rst_n && m_act && cyc == m_r;
    chk("psel", bus.psel, ep);
    chk("penable", bus.penable, ee);
    chk("nat_ready", nat_ready, er);
    chk("nat_rdata", nat_rdata, er ? m_rdata : 32'h0);
    chk("nat_err", nat_err, er ? m_err : 1'b0);
    chk("tmo_cnt", tmo_cnt, rst_n ? m_tmo : 0);
    if (ep) begin
      chk("paddr", bus.paddr, m_addr);
      chk("pwrite", bus.pwrite, m_wr);
      chk("pstrb", bus.pstrb, m_strb);
      chk("pwdata", bus.pwdata, m_wdata);
      chk("pprot", bus.pprot, 3'b000);
    end
  end

  int          lat, psel_at, pen_at;
  logic [31:0] got_rdata, seen_paddr, seen_pwdata;
  logic        got_err, seen_pwrite;
  logic [3:0]  seen_pstrb;

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      input int w, input logic [31:0] rd, input logic e, input bit perturb);
    sl_wait  = w;
    sl_rdata = rd;
    sl_err   = e;
    @(negedge clk);
    nat_valid = 1'b1;
    nat_addr  = addr;
    nat_wdata = wdata;
    nat_wstrb = strb;
    lat = -1; psel_at = -1; pen_at = -1;
    got_rdata = 'x; got_err = 1'bx;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.psel && psel_at < 0) begin
        psel_at    = k;
        seen_paddr = bus.paddr;
      end
      if (bus.penable) begin
        if (pen_at < 0) pen_at = k;
        seen_pwdata = bus.pwdata;
        seen_pstrb  = bus.pstrb;
        seen_pwrite = bus.pwrite;
      end
      if (k == 1 && perturb) begin
        nat_valid = 1'b0;
        nat_wdata = ~wdata;
        nat_wstrb = 4'hF;
        nat_addr  = addr + 32'h100;
      end
      if (nat_ready) begin
        lat       = k;
        got_rdata = nat_rdata;
        got_err   = nat_err;
      end
    end
    nat_valid = 1'b0;
  endtask

  int r1, r2, cnt;

  initial begin
    rst_n = 1'b0; nat_valid = 1'b0; valid0 = 1'b0;
    nat_addr = '0; nat_wdata = '0; nat_wstrb = '0;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    bus0.pready = 1'b0; bus0.prdata = '0; bus0.pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel", bus.psel, 0);
    chk("rst_ready", nat_ready, 0);
    chk("rst_tmo", tmo_cnt, 0);
    rst_n = 1'b1;

    xfer(32'h0000_0104, 32'h0, 4'b0000, 0, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("rd0_latency", lat, 3);
    chk("rd0_psel_cycle", psel_at, 1);
    chk("rd0_penable_cycle", pen_at, 2);
    chk("rd0_rdata", got_rdata, 32'hA5A5_0001);
    chk("rd0_err", got_err, 0);
    chk("rd0_paddr", seen_paddr, 32'h0000_0104);

    xfer(32'h0000_0200, 32'h1122_3344, 4'b0101, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("wr3_latency", lat, 6);
    chk("wr3_pwdata", seen_pwdata, 32'h1122_3344);
    chk("wr3_pstrb", seen_pstrb, 4'b0101);
    chk("wr3_pwrite", seen_pwrite, 1);
    chk("wr3_rdata", got_rdata, 0);
    chk("wr3_err", got_err, 0);

    xfer(32'h0000_0300, 32'h0, 4'b0000, 0, 32'h0, 1'b1, 1'b0);
    chk("slverr_latency", lat, 3);
    chk("slverr_err", got_err, 1);
    chk("slverr_rdata", got_rdata, 0);
    chk("slverr_tmo", tmo_cnt, 0);

    xfer(32'h0000_0400, 32'h0, 4'b0000, -1, 32'h7777_7777, 1'b0, 1'b0);
    chk("tmo_latency", lat, 6);
    chk("tmo_err", got_err, 1);
    chk("tmo_rdata", got_rdata, 0);
    chk("tmo_count", tmo_cnt, 1);

    sl_wait = 0; sl_rdata = 32'h5A5A_0002; sl_err = 1'b0;
    @(negedge clk);
    nat_valid = 1'b1; nat_addr = 32'h0000_2007; nat_wstrb = 4'b0000;
    r1 = -1; r2 = -1; seen_paddr = 'x;
    for (int k = 1; k <= 30 && r2 < 0; k++) begin
      @(negedge clk);
      if (k == 1) seen_paddr = bus.paddr;
      if (nat_ready) begin
        if (r1 < 0) r1 = k;
        else begin
          r2 = k;
          nat_valid = 1'b0;
        end
      end
    end
    nat_valid = 1'b0;
    chk("b2b_first_ready", r1, 3);
    chk("b2b_second_ready", r2, 7);
    chk("b2b_paddr_aligned", seen_paddr, 32'h0000_2004);

    sl_wait = -1;
    @(negedge clk);
    nat_valid = 1'b1; nat_addr = 32'h0000_0600; nat_wdata = 32'hCAFE_F00D; nat_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_mid_penable_before", bus.penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_psel_async", bus.psel, 0);
    chk("rst_mid_penable_async", bus.penable, 0);
    nat_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (nat_ready) cnt++;
    end
    chk("rst_mid_no_ready", cnt, 0);
    chk("rst_mid_tmo", tmo_cnt, 0);

    xfer(32'h0000_0700, 32'h8800_0000, 4'b1000, 0, 32'h1234_5678, 1'b0, 1'b0);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_pstrb", seen_pstrb, 4'b1000);

    @(negedge clk);
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ready0) cnt++;
    end
    chk("tmo0_no_ready", cnt, 0);
    chk("tmo0_psel_held", bus0.psel, 1);
    chk("tmo0_penable_held", bus0.penable, 1);
    chk("tmo0_err", err0, 0);
    chk("tmo0_rdata", rdata0, 0);
    chk("tmo0_count", tmo_cnt0, 0);
    chk("tmo0_pprot", bus0.pprot, 0);
    chk("tmo0_pwrite", bus0.pwrite, |nat_wstrb);
    chk("tmo0_pstrb", bus0.pstrb, nat_wstrb);
    chk("tmo0_pwdata", bus0.pwdata, nat_wdata);
    chk("tmo0_paddr", bus0.paddr, nat_addr & 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
